// File: rtl/pll_seq_pkg.sv
// Shared state encodings and sizing helpers for the PLL reset sequencer.
package pll_seq_pkg;

    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] pll_state_t;

    localparam pll_state_t PLL_RESET = 3'd0;
    localparam pll_state_t WAIT_LOCK = 3'd1;
    localparam pll_state_t DEBOUNCE  = 3'd2;
    localparam pll_state_t RUN       = 3'd3;
    localparam pll_state_t FAULT     = 3'd4;

    // The timer only ever counts up to (limit - 1), so clog2 of the largest limit suffices.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        if (m < 2) begin
            return 1;
        end else begin
            return $clog2(m);
        end
    endfunction

endpackage

// File: rtl/sync_bit.sv
// N-flop synchronizer for a single asynchronous level, cleared to 0 by rst_n.
module sync_bit #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    localparam int N_EFF = (N < 2) ? 2 : N;

    logic [N_EFF-1:0] sync_q;

    // Shift the raw level through the synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {N_EFF{1'b0}};
        end else begin
            sync_q <= {sync_q[N_EFF-2:0], d};
        end
    end

    assign q = sync_q[N_EFF-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer on the reference clock. Define PLL_SEQ_AUTO_RELOCK_EN to
// re-acquire lock automatically after a loss in RUN instead of latching FAULT.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 4,
    parameter int CNT_W          = 8
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic               clear,
    output logic               pll_rst,
    output logic               sys_rst_n,
    output logic               ready,
    output logic               fault,
    output logic [STATE_W-1:0] state,
    output logic [2:0]         retry_cnt,
    output logic [CNT_W-1:0]   lock_loss_cnt
);

    localparam int TMR_W = timer_width(LOCK_TIMEOUT, STABLE_CYCLES, PLL_RST_CYCLES);

    localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(PLL_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that first sees lk counts as the first stable cycle.
    localparam logic [TMR_W-1:0] DEB_LAST  = TMR_W'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0);
    localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRIES);
    localparam logic [CNT_W-1:0] LOSS_SAT  = {CNT_W{1'b1}};

    logic             lk_s;
    logic [2:0]       retry_inc_s;

    pll_state_t       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [2:0]       retry_q, retry_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_n_q, sys_rst_n_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;

    sync_bit #(
        .N(SYNC_STAGES)
    ) u_lock_sync (
        .clk  (refclk),
        .rst_n(rst_n),
        .d    (pll_locked),
        .q    (lk_s)
    );

    assign retry_inc_s = retry_q + 3'd1;

    // Next-state, shared timer and counter logic.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TMR_W'(1);
        retry_d = retry_q;
        loss_d  = loss_q;

        case (state_q)
            PLL_RESET: begin
                if (timer_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                end else begin
                    state_d = PLL_RESET;
                end
            end
            WAIT_LOCK: begin
                if (lk_s) begin
                    state_d = DEBOUNCE;
                end else if (timer_q == LOCK_LAST) begin
                    retry_d = retry_inc_s;
                    state_d = (retry_inc_s == RETRY_MAX) ? FAULT : PLL_RESET;
                end else begin
                    state_d = WAIT_LOCK;
                end
            end
            DEBOUNCE: begin
                if (!lk_s) begin
                    state_d = WAIT_LOCK;
                end else if (timer_q == DEB_LAST) begin
                    state_d = RUN;
                    retry_d = 3'd0;
                end else begin
                    state_d = DEBOUNCE;
                end
            end
            RUN: begin
                timer_d = {TMR_W{1'b0}};
                if (!lk_s) begin
                    loss_d = (loss_q == LOSS_SAT) ? LOSS_SAT : loss_q + CNT_W'(1);
`ifdef PLL_SEQ_AUTO_RELOCK_EN
                    state_d = PLL_RESET;
`else
                    state_d = FAULT;
`endif
                end else begin
                    state_d = RUN;
                end
            end
            FAULT: begin
                timer_d = {TMR_W{1'b0}};
                if (clear) begin
                    state_d = PLL_RESET;
                end else begin
                    state_d = FAULT;
                end
            end
            default: begin
                state_d = PLL_RESET;
                timer_d = {TMR_W{1'b0}};
            end
        endcase

        // clear overrides any same-cycle increment.
        retry_d = clear ? 3'd0 : retry_d;
        loss_d  = clear ? {CNT_W{1'b0}} : loss_d;
        timer_d = (state_d != state_q) ? {TMR_W{1'b0}} : timer_d;
    end

    // Outputs decoded from the next state so they change together with the state register.
    always_comb begin
        pll_rst_d   = (state_d == PLL_RESET) || (state_d == FAULT);
        sys_rst_n_d = (state_d == RUN);
        ready_d     = (state_d == RUN);
        fault_d     = (state_d == FAULT);
    end

    // State, timer, counters and registered outputs.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PLL_RESET;
            timer_q     <= {TMR_W{1'b0}};
            retry_q     <= 3'd0;
            loss_q      <= {CNT_W{1'b0}};
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign sys_rst_n     = sys_rst_n_q;
    assign ready         = ready_q;
    assign fault         = fault_q;
    assign state         = state_q;
    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed and randomized bench for pll_reset_sequencer against a cycle-level reference model.
module tb_pll_reset_sequencer;

    localparam int SYNC = 2;
    localparam int PRC  = 4;
    localparam int TO   = 100;
    localparam int STB  = 8;
    localparam int MAXR = 3;
    localparam int CW   = 2;
    localparam int LOSS_MAX = 3;
`ifdef PLL_SEQ_AUTO_RELOCK_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam int S_RST = 0, S_WAIT = 1, S_DEB = 2, S_RUN = 3, S_FLT = 4;

    logic          refclk;
    logic          rst_n;
    logic          pll_locked;
    logic          clear;
    logic          pll_rst;
    logic          sys_rst_n;
    logic          ready;
    logic          fault;
    logic [2:0]    state;
    logic [2:0]    retry_cnt;
    logic [CW-1:0] lock_loss_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model: state by name, cycles spent in it, stable-lock run length, counters.
    int   m_st, m_age, m_stable, m_retry, m_loss;
    logic m_hist[$];

    pll_reset_sequencer #(
        .SYNC_STAGES   (SYNC),
        .PLL_RST_CYCLES(PRC),
        .LOCK_TIMEOUT  (TO),
        .STABLE_CYCLES (STB),
        .MAX_RETRIES   (MAXR),
        .CNT_W         (CW)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .clear        (clear),
        .pll_rst      (pll_rst),
        .sys_rst_n    (sys_rst_n),
        .ready        (ready),
        .fault        (fault),
        .state        (state),
        .retry_cnt    (retry_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = S_RST; m_age = 0; m_stable = 0; m_retry = 0; m_loss = 0;
        m_hist = {};
        for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
    endtask

    // Advance the model across one refclk edge using the level lk had before the edge.
    task automatic model_edge(input logic lck, input logic clr);
        logic lk_o;
        int   nxt;
        lk_o = m_hist[0];
        nxt  = m_st;
        m_age++;
        case (m_st)
            S_RST:  if (m_age >= PRC) nxt = S_WAIT;
            S_WAIT: begin
                if (lk_o) begin
                    nxt = S_DEB;
                    m_stable = 1;
                end else if (m_age >= TO) begin
                    m_retry++;
                    nxt = (m_retry >= MAXR) ? S_FLT : S_RST;
                end
            end
            S_DEB: begin
                if (!lk_o) nxt = S_WAIT;
                else begin
                    m_stable++;
                    if (m_stable >= STB) begin
                        nxt = S_RUN;
                        m_retry = 0;
                    end
                end
            end
            S_RUN: begin
                if (!lk_o) begin
                    m_loss = (m_loss >= LOSS_MAX) ? LOSS_MAX : m_loss + 1;
                    nxt = AUTO ? S_RST : S_FLT;
                end
            end
            S_FLT:  if (clr) nxt = S_RST;
            default: nxt = S_RST;
        endcase
        if (clr) begin
            m_retry = 0;
            m_loss = 0;
        end
        if (nxt != m_st) m_age = 0;
        m_st = nxt;
        m_hist.push_back(lck);
        void'(m_hist.pop_front());
    endtask

    task automatic compare_all();
        chk("state", state, m_st);
        chk("pll_rst", pll_rst, (m_st == S_RST || m_st == S_FLT) ? 1 : 0);
        chk("sys_rst_n", sys_rst_n, (m_st == S_RUN) ? 1 : 0);
        chk("ready", ready, (m_st == S_RUN) ? 1 : 0);
        chk("fault", fault, (m_st == S_FLT) ? 1 : 0);
        chk("retry_cnt", retry_cnt, m_retry);
        chk("lock_loss_cnt", lock_loss_cnt, m_loss);
    endtask

    task automatic tick(input logic lck, input logic clr);
        pll_locked = lck;
        clear = clr;
        @(posedge refclk);
        model_edge(lck, clr);
        #1;
        compare_all();
    endtask

    // Assert rst_n between edges and confirm outputs drop before the next edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_pll_rst", pll_rst, 1);
        chk("rst_sys_rst_n", sys_rst_n, 0);
        chk("rst_ready", ready, 0);
        chk("rst_fault", fault, 0);
        chk("rst_state", state, S_RST);
        chk("rst_retry", retry_cnt, 0);
        chk("rst_loss", lock_loss_cnt, 0);
        model_reset();
        @(posedge refclk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_ready(input int budget, output int n);
        n = 0;
        for (int i = 1; i <= budget; i++) begin
            tick(1'b1, 1'b0);
            if (ready === 1'b1) begin
                n = i;
                break;
            end
        end
        chk("ready_reached", (n > 0) ? 1 : 0, 1);
    endtask

    initial begin
        int n;
        int dur;
        logic lv;
        rst_n = 1'b1;
        pll_locked = 1'b0;
        clear = 1'b0;
        model_reset();
        #2;
        do_reset();

        // Bring-up: pll_rst released after 4 cycles, system released 10 cycles after lock.
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0, 1'b0);
            if (i == 3) chk("pll_rst_held", pll_rst, 1);
            if (i == 4) chk("pll_rst_fall", pll_rst, 0);
        end
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1'b1, 1'b0);
            if (sys_rst_n === 1'b1) begin
                n = i;
                break;
            end
        end
        chk("release_latency", n, 10);
        chk("bringup_ready", ready, 1);
        chk("bringup_retry", retry_cnt, 0);

        // Lock loss in RUN: sys_rst_n low on the third cycle.
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("loss_sys_still_high", sys_rst_n, 1);
        tick(1'b0, 1'b0);
        chk("loss_sys_low", sys_rst_n, 0);
        chk("loss_count", lock_loss_cnt, 1);
        chk("loss_state", state, AUTO ? 32'd0 : 32'd4);

        // Lock never arrives: three attempts then FAULT.
        do_reset();
        n = 0;
        for (int i = 1; i <= 400; i++) begin
            tick(1'b0, 1'b0);
            if (fault === 1'b1) begin
                n = i;
                break;
            end
        end
        chk("fault_latency", n, 3 * (PRC + TO));
        chk("fault_state", state, S_FLT);
        chk("fault_pll_rst", pll_rst, 1);
        chk("fault_retry", retry_cnt, MAXR);
        tick(1'b0, 1'b1);
        chk("clear_state", state, S_RST);
        chk("clear_retry", retry_cnt, 0);

        // One-cycle dropout during DEBOUNCE restarts qualification.
        for (int i = 0; i < PRC; i++) tick(1'b0, 1'b0);
        chk("deb_wait_entry", state, S_WAIT);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        chk("deb_back_to_wait", state, S_WAIT);
        chk("deb_no_loss", lock_loss_cnt, 0);
        chk("deb_not_ready", ready, 0);
        wait_ready(20, n);
        chk("deb_restart_latency", n, 8);

`ifdef PLL_SEQ_AUTO_RELOCK_EN
        // Repeated losses saturate the 2-bit counter.
        for (int k = 1; k <= 5; k++) begin
            tick(1'b0, 1'b0);
            tick(1'b0, 1'b0);
            tick(1'b0, 1'b0);
            chk("sat_loss", lock_loss_cnt, (k > LOSS_MAX) ? LOSS_MAX : k);
            wait_ready(40, n);
        end
`endif
        // A clear on the same edge as a loss leaves the counter at zero.
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        chk("clear_vs_loss", lock_loss_cnt, 0);
        chk("clear_vs_loss_state", state, AUTO ? 32'd0 : 32'd4);

        // Return to RUN, then assert rst_n asynchronously.
        if (state === 3'd4) tick(1'b1, 1'b1);
        wait_ready(40, n);
        do_reset();

        // Randomized lock activity with occasional clear pulses.
        for (int c = 0; c < 3000; c += dur) begin
            lv  = ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0;
            dur = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 130);
            for (int j = 0; j < dur; j++) begin
                tick(lv, ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
            end
        end
        tick(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
